// File: rtl/input_cond_pkg.sv
// Shared types and default constants for the input conditioner slice.
package input_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } key_state_t;

  localparam int unsigned DEBOUNCE_DEFAULT = 1000000;
  localparam int unsigned CNT_W_DEFAULT    = 20;

endpackage

// File: rtl/debounce_fsm.sv
// Single-bit active-low key debouncer: 2-flop synchronizer, 4-state FSM with
// hold counter, registered clean level, press/release pulses and press toggle.
module debounce_fsm
  import input_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic press,
  output logic rel,
  output logic toggle
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  key_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             press_ev, rel_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    press_ev = 1'b0;
    rel_ev   = 1'b0;
    case (state)
      RELEASED: begin
        if (!s2) begin
          state_n = PRESS_PEND;
          cnt_n   = '0;
        end
      end
      PRESS_PEND: begin
        if (s2) begin
          state_n = RELEASED;
          cnt_n   = '0;
        end else if (cnt == TERM) begin
          state_n  = PRESSED;
          cnt_n    = '0;
          press_ev = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (s2) begin
          state_n = RELEASE_PEND;
          cnt_n   = '0;
        end
      end
      RELEASE_PEND: begin
        if (!s2) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == TERM) begin
          state_n = RELEASED;
          cnt_n   = '0;
          rel_ev  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = RELEASED;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so the clean level moves on the
  // same edge as the accepting transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RELEASED;
      cnt    <= '0;
      clean  <= 1'b1;
      press  <= 1'b0;
      rel    <= 1'b0;
      toggle <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      clean  <= !((state_n == PRESSED) || (state_n == RELEASE_PEND));
      press  <= press_ev;
      rel    <= rel_ev;
      toggle <= toggle ^ press_ev;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes/debounces SW[SW_W-1:0] and active-low KEY0 for the display block.
// Define INPUT_COND_SW_DEBOUNCE_EN to debounce the switch vector as well.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned SW_W            = 10,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] SW,
  input  logic            KEY0,
  output logic [SW_W-1:0] sw_out,
  output logic            key0_clean,
  output logic            key_press,
  output logic            key_release,
  output logic            neg_mode
);

  logic [SW_W-1:0] sw_s1, sw_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
    end
  end

`ifdef INPUT_COND_SW_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] SW_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0]  sw_prev;
  logic [CNT_W-1:0] sw_cnt;

  // sw_prev detects any movement of the synchronized vector; movement while
  // counting restarts the hold window from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_prev <= '0;
      sw_cnt  <= '0;
      sw_out  <= '0;
    end else begin
      sw_prev <= sw_s2;
      if (sw_s2 == sw_out) begin
        sw_cnt <= '0;
      end else if (sw_s2 != sw_prev) begin
        sw_cnt <= '0;
      end else if (sw_cnt == SW_TERM) begin
        sw_out <= sw_s2;
        sw_cnt <= '0;
      end else begin
        sw_cnt <= sw_cnt + CNT_W'(1);
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_out <= '0;
    end else begin
      sw_out <= sw_s2;
    end
  end
`endif

  debounce_fsm #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_key0 (
    .clk   (clk),
    .rst   (rst),
    .raw   (KEY0),
    .clean (key0_clean),
    .press (key_press),
    .rel   (key_release),
    .toggle(neg_mode)
  );

endmodule
